// File: rtl/uart_pkg.sv
// Shared types for the parameterised UART transmitter: the parity selector
// and the transmit FSM state encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port. rd_data_o changes only on a pop,
// so it holds the popped word until the next pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             push_ok, pop_ok;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = rd_data_q;
  assign push_ok   = push_i & ~full_o;
  assign pop_ok    = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small transmit FIFO; frames are sent
// back-to-back while the FIFO holds data.
module uart_tx_param import uart_pkg::*; #(
  parameter int      CLKS_PER_BIT = 434,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 4
) (
  input  logic                          CLK50MHZ_i,
  input  logic                          RESET_N_i,
  input  logic [DATA_BITS-1:0]          wr_data_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_q, stop_d;
  logic                 pop, full, empty, tick, par_bit;
  logic [DATA_BITS-1:0] word;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (CLK50MHZ_i),
    .rst_ni    (RESET_N_i),
    .push_i    (wr_valid_i),
    .wr_data_i (wr_data_i),
    .pop_i     (pop),
    .rd_data_o (word),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level_o)
  );

  assign wr_ready_o = ~full;
  assign busy_o     = (state_q != ST_IDLE) | ~empty;
  assign tick       = (baud_q == BAUD_MAX);
  assign par_bit    = (PARITY == PAR_ODD) ? ~^word : ^word;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    stop_d    = stop_q;
    pop       = 1'b0;
    if (state_q != ST_IDLE) baud_d = tick ? '0 : baud_q + 1'b1;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = ST_START;
        baud_d  = '0;
      end
      ST_START: if (tick) begin
        state_d   = ST_DATA;
        bit_idx_d = '0;
      end
      ST_DATA: if (tick) begin
        if (bit_idx_q == IDX_MAX) begin
          state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          stop_d  = 1'b0;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      ST_PARITY: if (tick) begin
        state_d = ST_STOP;
        stop_d  = 1'b0;
      end
      // Last stop bit: chain straight into the next frame when data is waiting.
      ST_STOP: if (tick) begin
        if (stop_q == STOP_LAST) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          stop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ_i or negedge RESET_N_i) begin
    if (!RESET_N_i) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      stop_q    <= stop_d;
    end
  end

  // Decoded from reset-cleared state, so reset drives the line high immediately.
  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      ST_START:  tx_o = 1'b0;
      ST_DATA:   tx_o = word[bit_idx_q];
      ST_PARITY: tx_o = par_bit;
      default:   tx_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: default framing, parity, 7N2, FIFO fill and
// back-to-back frames, and reset in mid-frame.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int CPB   = 434;
  localparam int CPB_S = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] d_wdata, e_wdata, o_wdata;
  logic [6:0] s_wdata;
  logic       d_valid, e_valid, o_valid, s_valid;
  logic       d_ready, e_ready, o_ready, s_ready;
  logic       d_tx, e_tx, o_tx, s_tx;
  logic       d_busy, e_busy, o_busy, s_busy;
  logic [2:0] d_level, e_level, o_level, s_level;

  int checks = 0;
  int errors = 0;

  uart_tx_param u_def (
    .CLK50MHZ_i(clk), .RESET_N_i(rst_n), .wr_data_i(d_wdata), .wr_valid_i(d_valid),
    .wr_ready_o(d_ready), .tx_o(d_tx), .busy_o(d_busy), .level_o(d_level));

  uart_tx_param #(.CLKS_PER_BIT(CPB_S), .PARITY(PAR_EVEN)) u_even (
    .CLK50MHZ_i(clk), .RESET_N_i(rst_n), .wr_data_i(e_wdata), .wr_valid_i(e_valid),
    .wr_ready_o(e_ready), .tx_o(e_tx), .busy_o(e_busy), .level_o(e_level));

  uart_tx_param #(.CLKS_PER_BIT(CPB_S), .PARITY(PAR_ODD)) u_odd (
    .CLK50MHZ_i(clk), .RESET_N_i(rst_n), .wr_data_i(o_wdata), .wr_valid_i(o_valid),
    .wr_ready_o(o_ready), .tx_o(o_tx), .busy_o(o_busy), .level_o(o_level));

  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .CLK50MHZ_i(clk), .RESET_N_i(rst_n), .wr_data_i(s_wdata), .wr_valid_i(s_valid),
    .wr_ready_o(s_ready), .tx_o(s_tx), .busy_o(s_busy), .level_o(s_level));

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return d_tx;
      1:       return e_tx;
      2:       return o_tx;
      default: return s_tx;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return d_busy;
      1:       return e_busy;
      2:       return o_busy;
      default: return s_busy;
    endcase
  endfunction

  // Called on the first cycle of a start bit; samples the first and last cycle of
  // every bit slot and returns on the first cycle after the frame.
  task automatic grab(input int sel, input int cpb, input int nslots,
                      output logic [15:0] first, output logic [15:0] last, output logic bsy_end);
    first = '0;
    last  = '0;
    bsy_end = 1'b0;
    for (int b = 0; b < nslots; b++) begin
      first[b] = tx_of(sel);
      repeat (cpb - 1) @(negedge clk);
      last[b] = tx_of(sel);
      if (b == nslots - 1) bsy_end = busy_of(sel);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    {d_valid, e_valid, o_valid, s_valid} = '0;
    d_wdata = '0; e_wdata = '0; o_wdata = '0; s_wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (d_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", d_tx); end
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", d_ready); end
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", d_busy); end
    checks++; if (d_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", d_level); end
    checks++; if ({e_tx, o_tx, s_tx} !== 3'b111) begin errors++; $display("FAIL reset_tx_all: got %b want 111", {e_tx, o_tx, s_tx}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] f, l;
    logic be;
    d_wdata = 8'h55; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    checks++; if (d_tx !== 1'b1) begin errors++; $display("FAIL basic_pre_start: got %b want 1", d_tx); end
    checks++; if (d_level !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d want 1", d_level); end
    @(negedge clk);
    grab(0, CPB, 10, f, l, be);
    checks++; if (f !== 16'h02AA) begin errors++; $display("FAIL basic_first: got %h want 02aa", f); end
    checks++; if (l !== 16'h02AA) begin errors++; $display("FAIL basic_last: got %h want 02aa", l); end
    checks++; if (be !== 1'b1) begin errors++; $display("FAIL basic_busy_stop: got %b want 1", be); end
    checks++; if ({d_tx, d_busy} !== 2'b10) begin errors++; $display("FAIL basic_idle: got %b want 10", {d_tx, d_busy}); end
  endtask

  task automatic test_parity_even;
    logic [15:0] f, l;
    logic be;
    e_wdata = 8'hA5; e_valid = 1'b1;
    @(negedge clk);
    e_valid = 1'b0;
    checks++; if (e_tx !== 1'b1) begin errors++; $display("FAIL even_pre_start: got %b want 1", e_tx); end
    @(negedge clk);
    grab(1, CPB_S, 11, f, l, be);
    checks++; if (f !== 16'h054A) begin errors++; $display("FAIL even_first: got %h want 054a", f); end
    checks++; if (l !== 16'h054A) begin errors++; $display("FAIL even_last: got %h want 054a", l); end
    checks++; if ({be, e_busy} !== 2'b10) begin errors++; $display("FAIL even_len: got %b want 10", {be, e_busy}); end
  endtask

  task automatic test_parity_odd;
    logic [15:0] f, l;
    logic be;
    o_wdata = 8'hA5; o_valid = 1'b1;
    @(negedge clk);
    o_valid = 1'b0;
    @(negedge clk);
    grab(2, CPB_S, 11, f, l, be);
    checks++; if (f !== 16'h074A) begin errors++; $display("FAIL odd_first: got %h want 074a", f); end
    checks++; if (l !== 16'h074A) begin errors++; $display("FAIL odd_last: got %h want 074a", l); end
    checks++; if ({be, o_busy} !== 2'b10) begin errors++; $display("FAIL odd_len: got %b want 10", {be, o_busy}); end
  endtask

  task automatic test_7n2;
    logic [15:0] f, l;
    logic be;
    s_wdata = 7'h7F; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_tx !== 1'b0) begin errors++; $display("FAIL 7n2_start: got %b want 0", s_tx); end
    grab(3, CPB, 10, f, l, be);
    checks++; if (f !== 16'h03FE) begin errors++; $display("FAIL 7n2_first: got %h want 03fe", f); end
    checks++; if (l !== 16'h03FE) begin errors++; $display("FAIL 7n2_last: got %h want 03fe", l); end
    checks++; if ({be, s_busy} !== 2'b10) begin errors++; $display("FAIL 7n2_stop_len: got %b want 10", {be, s_busy}); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  w   [6] = '{8'h11, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'hFF};
    logic [15:0] exp [5] = '{16'h0222, 16'h0278, 16'h0386, 16'h021E, 16'h03E0};
    logic [15:0] f, l;
    logic be;
    int lows;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        checks++; if ({d_ready, d_level} !== 4'b0100) begin errors++; $display("FAIL fifo_full: got ready/level %b want 0100", {d_ready, d_level}); end
      end
      d_wdata = w[k]; d_valid = 1'b1;
      @(negedge clk);
      if (k == 1) begin
        checks++; if (d_tx !== 1'b0) begin errors++; $display("FAIL fifo_first_pop: got %b want 0", d_tx); end
      end
    end
    d_valid = 1'b0;
    checks++; if (d_level !== 3'd4) begin errors++; $display("FAIL fifo_drop: got %0d want 4", d_level); end
    repeat (CPB * 10 - 4) @(negedge clk);
    checks++; if (d_level !== 3'd3) begin errors++; $display("FAIL fifo_level_f2: got %0d want 3", d_level); end
    for (int fr = 1; fr < 5; fr++) begin
      grab(0, CPB, 10, f, l, be);
      checks++; if (f !== exp[fr] || l !== exp[fr] || be !== 1'b1) begin
        errors++; $display("FAIL fifo_frame%0d: got %h/%h busy %b want %h busy 1", fr, f, l, be, exp[fr]);
      end
    end
    checks++; if ({d_tx, d_busy, d_level} !== 5'b10000) begin errors++; $display("FAIL fifo_drain: got %b want 10000", {d_tx, d_busy, d_level}); end
    lows = 0;
    repeat (CPB * 10) begin
      @(negedge clk);
      if (d_tx !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL fifo_no_sixth: got %0d low cycles want 0", lows); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] w [3] = '{8'hA5, 8'h3C, 8'hC3};
    logic [15:0] f, l;
    logic be;
    int lows;
    for (int k = 0; k < 3; k++) begin
      d_wdata = w[k]; d_valid = 1'b1;
      @(negedge clk);
    end
    d_valid = 1'b0;
    checks++; if (d_level !== 3'd2) begin errors++; $display("FAIL rst_queued: got %0d want 2", d_level); end
    repeat (1899) @(negedge clk);
    checks++; if (d_tx !== 1'b0) begin errors++; $display("FAIL rst_data_bit3: got %b want 0", d_tx); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (d_tx !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b want 1", d_tx); end
    checks++; if ({d_ready, d_busy, d_level} !== 5'b10000) begin errors++; $display("FAIL rst_async_state: got %b want 10000", {d_ready, d_busy, d_level}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (CPB * 20) begin
      @(negedge clk);
      if (d_tx !== 1'b1 || d_busy !== 1'b0) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL rst_residual: got %0d active cycles want 0", lows); end
    d_wdata = 8'h3C; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    checks++; if (d_tx !== 1'b1) begin errors++; $display("FAIL rst_post_pre: got %b want 1", d_tx); end
    @(negedge clk);
    grab(0, CPB, 10, f, l, be);
    checks++; if (f !== 16'h0278 || l !== 16'h0278) begin errors++; $display("FAIL rst_post_frame: got %h/%h want 0278", f, l); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_even();
    test_parity_odd();
    test_7n2();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default PAR_NONE, one of PAR_NONE, PAR_EVEN, PAR_ODD.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..64.
REQ-006 CLK50MHZ_i  in  1  sole clock, rising edge.
REQ-007 RESET_N_i  in  1  asynchronous active-low reset.
REQ-008 wr_data_i  in  DATA_BITS  word to transmit.
REQ-009 wr_valid_i  in  1  write request.
REQ-010 wr_ready_o  out  1  FIFO can accept a word.
REQ-011 tx_o  out  1  serial line; idle high.
REQ-012 busy_o  out  1  frame in progress or FIFO non-empty.
REQ-013 level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A word shall be accepted on a rising edge where wr_valid_i and wr_ready_o are both high.
REQ-015 wr_ready_o shall be high exactly when level_o < FIFO_DEPTH; a write while full shall be dropped with no state change.
REQ-016 FSM states shall be IDLE, START, DATA, PARITY, STOP; IDLE -> START on the edge that pops a non-empty FIFO.
REQ-017 A word accepted at edge N into an empty FIFO with FSM in IDLE shall be popped at edge N+1; tx_o shall go low after edge N+1.
REQ-018 Each of START, each DATA bit, PARITY and each STOP bit shall hold tx_o for exactly CLKS_PER_BIT cycles.
REQ-019 Data shall be sent LSB first, DATA_BITS bits, counted by a bit index that resets to 0 on entry to DATA.
REQ-020 DATA -> PARITY after the last data bit when PARITY != PAR_NONE; otherwise DATA -> STOP.
REQ-021 Parity bit shall be XOR of all data bits for PAR_EVEN and its inverse for PAR_ODD.
REQ-022 STOP shall drive tx_o high for STOP_BITS * CLKS_PER_BIT cycles.
REQ-023 On STOP completion the FSM shall pop the next word and enter START directly if the FIFO is non-empty, giving back-to-back frames with no idle gap; otherwise it shall enter IDLE.
REQ-024 A simultaneous push and pop shall leave level_o unchanged, and the pushed word shall be stored; a push while full is refused even in a pop cycle.
REQ-025 The baud counter shall be width $clog2(CLKS_PER_BIT) and shall count 0..CLKS_PER_BIT-1, wrapping to 0 at each bit boundary.
REQ-026 busy_o shall be low only when the FSM is in IDLE and level_o == 0.

Reset
REQ-027 While RESET_N_i is low: tx_o = 1, wr_ready_o = 1, busy_o = 0, level_o = 0, FSM = IDLE, all counters 0.
REQ-028 Reset asserted mid-frame shall force tx_o high immediately (asynchronously), discard the frame and the FIFO contents, and never emit a partial stop sequence.
REQ-029 After reset release, the first accepted write shall follow the REQ-017 timing.

Structure
REQ-030 Package uart_pkg shall hold the parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the tx_state_e FSM enum.
REQ-031 The FIFO shall be the sub-module sync_fifo (params WIDTH, DEPTH), with a registered read and a full/empty/level interface.

Verification
REQ-032 Defaults, write 0x55 -> tx_o low 434 cycles, then 1,0,1,0,1,0,1,0, each 434 cycles, then high; frame = 4340 cycles.
REQ-033 PARITY=PAR_EVEN, write 0xA5 -> parity bit 0; PARITY=PAR_ODD, same word -> parity bit 1; frame = 11 bit-times.
REQ-034 DATA_BITS=7, STOP_BITS=2, write 0x7F -> start, seven 1s, stop high for 868 cycles; frame = 10 bit-times.
REQ-035 FIFO_DEPTH=4, write 6 words on consecutive cycles -> words 1-5 accepted (word 1 popped immediately) and word 6 refused with wr_ready_o low; the 5 frames are back-to-back with no idle gap.
REQ-036 Assert RESET_N_i during DATA bit 3 with 2 words queued -> tx_o high at once, level_o = 0, busy_o = 0; after release, no residual frames are sent.
